// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg
//   Shared encodings for the simple CPU: controller state enum, instruction
//   class / sub-operation codes, register-field selects, writeback source
//   selects and memory command codes. Imported by the controller, decoder
//   and datapath so that all three agree on every encoding.
package cpu_controller_pkg;

    typedef enum logic [4:0] {
        S_RST        = 5'd0,
        S_IF1        = 5'd1,
        S_IF2        = 5'd2,
        S_UPDATE_PC  = 5'd3,
        S_DECODE     = 5'd4,
        S_GET_A      = 5'd5,
        S_GET_B      = 5'd6,
        S_EXEC       = 5'd7,
        S_WRITE_REG  = 5'd8,
        S_WRITE_IMM  = 5'd9,
        S_LOAD_ADDR  = 5'd10,
        S_MEM_READ   = 5'd11,
        S_MEM_WB     = 5'd12,
        S_STR_GET_RD = 5'd13,
        S_STR_PASS   = 5'd14,
        S_WRITE_MEM  = 5'd15,
        S_HALT       = 5'd16
    } state_t;

    // Instruction classes (opcode field)
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // Sub-operations (op field)
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MEM     = 2'b00;

    // One-hot register-field select
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    // Writeback source select (2'b01 is reserved)
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // Memory command
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

endpackage

// File: rtl/cpu_controller.sv
// cpu_controller
//   Moore FSM sequencing fetch, decode, execute and memory access for the
//   simple CPU datapath.
//
//   state        | meaning
//   -------------+------------------------------------------------
//   RST          | reset PC to zero
//   IF1          | present PC on address bus, start read
//   IF2          | keep reading, latch instruction register
//   UPDATE_PC    | PC <= PC + 1
//   DECODE       | branch on {opcode, op}
//   GET_A        | Rn -> A
//   GET_B        | Rm -> B
//   EXEC         | ALU/shifter result -> C (or status for CMP)
//   WRITE_REG    | C -> Rd
//   WRITE_IMM    | sximm8 -> Rn
//   LOAD_ADDR    | C -> data address register
//   MEM_READ     | read data memory at data address
//   MEM_WB       | mdata -> Rd
//   STR_GET_RD   | Rd -> B
//   STR_PASS     | pass B through ALU into C (store data)
//   WRITE_MEM    | write C to data memory
//   HALT         | stopped until reset
//
//   Ports
//     clk, reset_n        clock, asynchronous active-low reset
//     opcode, op          instruction class and sub-operation from the IR
//     nsel                one-hot register field select (Rn/Rd/Rm)
//     loada..loads, write datapath register enables and regfile write
//     asel, bsel          A zero select, B sximm5 select
//     vsel                writeback source select
//     load_ir, load_pc, reset_pc, addr_sel, load_addr   fetch/address control
//     mem_cmd             memory command (none/read/write)
//     halted              high only in HALT
module cpu_controller
    import cpu_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_RST;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RST:       state_nxt = S_IF1;
            S_IF1:       state_nxt = S_IF2;
            S_IF2:       state_nxt = S_UPDATE_PC;
            S_UPDATE_PC: state_nxt = S_DECODE;
            S_DECODE: begin
                state_nxt = S_IF1;  // unrecognised codes act as NOP
                case (opcode)
                    OPC_HALT: state_nxt = S_HALT;
                    OPC_MOV: begin
                        if (op == OP_MOV_IMM)      state_nxt = S_WRITE_IMM;
                        else if (op == OP_MOV_REG) state_nxt = S_GET_B;
                    end
                    OPC_ALU: state_nxt = (op == OP_MVN) ? S_GET_B : S_GET_A;
                    OPC_LDR, OPC_STR: begin
                        if (op == OP_MEM) state_nxt = S_GET_A;
                    end
                    default: state_nxt = S_IF1;
                endcase
            end
            S_GET_A:     state_nxt = (opcode == OPC_ALU) ? S_GET_B : S_EXEC;
            S_GET_B:     state_nxt = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OPC_MOV:          state_nxt = S_WRITE_REG;
                    OPC_ALU:          state_nxt = (op == OP_CMP) ? S_IF1 : S_WRITE_REG;
                    OPC_LDR, OPC_STR: state_nxt = S_LOAD_ADDR;
                    default:          state_nxt = S_IF1;
                endcase
            end
            S_WRITE_REG:  state_nxt = S_IF1;
            S_WRITE_IMM:  state_nxt = S_IF1;
            S_LOAD_ADDR:  state_nxt = (opcode == OPC_LDR) ? S_MEM_READ : S_STR_GET_RD;
            S_MEM_READ:   state_nxt = S_MEM_WB;
            S_MEM_WB:     state_nxt = S_IF1;
            S_STR_GET_RD: state_nxt = S_STR_PASS;
            S_STR_PASS:   state_nxt = S_WRITE_MEM;
            S_WRITE_MEM:  state_nxt = S_IF1;
            S_HALT:       state_nxt = S_HALT;
            default:      state_nxt = S_RST;
        endcase
    end

    // Output decode. EXEC is the one state whose operand selects depend on
    // the instruction; the IR is held from UPDATE_PC to the next IF2, so
    // these outputs stay constant for the whole EXEC cycle.
    always_comb begin
        nsel      = NSEL_NONE;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = VSEL_C;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = MEM_NONE;
        halted    = 1'b0;
        unique case (state)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                load_ir  = 1'b1;
            end
            S_UPDATE_PC: load_pc = 1'b1;
            S_DECODE: ;
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_EXEC: begin
                case (opcode)
                    OPC_MOV: begin
                        asel  = 1'b1;
                        loadc = 1'b1;
                    end
                    OPC_ALU: begin
                        if (op == OP_CMP) loads = 1'b1;
                        else              loadc = 1'b1;
                    end
                    OPC_LDR, OPC_STR: begin
                        bsel  = 1'b1;
                        loadc = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WRITE_REG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_WRITE_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM8;
                write = 1'b1;
            end
            S_LOAD_ADDR: load_addr = 1'b1;
            S_MEM_READ:  mem_cmd   = MEM_READ;
            S_MEM_WB: begin
                mem_cmd = MEM_READ;
                nsel    = NSEL_RD;
                vsel    = VSEL_MDATA;
                write   = 1'b1;
            end
            S_STR_GET_RD: begin
                nsel  = NSEL_RD;
                loadb = 1'b1;
            end
            S_STR_PASS: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_WRITE_MEM: mem_cmd = MEM_WRITE;
            S_HALT:      halted  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic [2:0] nsel;
    logic       loada, loadb, loadc, loads, write, asel, bsel;
    logic [1:0] vsel;
    logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       halted;

    int total = 0;
    int bad = 0;

    cpu_controller dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .op(op),
        .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .write(write), .asel(asel), .bsel(bsel),
        .vsel(vsel), .load_ir(load_ir), .load_pc(load_pc),
        .reset_pc(reset_pc), .addr_sel(addr_sel), .load_addr(load_addr),
        .mem_cmd(mem_cmd), .halted(halted)
    );

    always #5 clk = ~clk;

    // Bench-side packing of all outputs into one word:
    // [19:17] nsel, 16 loada, 15 loadb, 14 loadc, 13 loads, 12 write,
    // 11 asel, 10 bsel, [9:8] vsel, 7 load_ir, 6 load_pc, 5 reset_pc,
    // 4 addr_sel, 3 load_addr, [2:1] mem_cmd, 0 halted
    logic [19:0] obs;
    assign obs = {nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel,
                  load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};

    localparam logic [19:0] N_RN    = 20'h20000;
    localparam logic [19:0] N_RD    = 20'h40000;
    localparam logic [19:0] N_RM    = 20'h80000;
    localparam logic [19:0] LOADA   = 20'h10000;
    localparam logic [19:0] LOADB   = 20'h08000;
    localparam logic [19:0] LOADC   = 20'h04000;
    localparam logic [19:0] LOADS   = 20'h02000;
    localparam logic [19:0] WRITE   = 20'h01000;
    localparam logic [19:0] ASEL    = 20'h00800;
    localparam logic [19:0] BSEL    = 20'h00400;
    localparam logic [19:0] V_IMM8  = 20'h00200;
    localparam logic [19:0] V_MDATA = 20'h00300;
    localparam logic [19:0] LOAD_IR = 20'h00080;
    localparam logic [19:0] LOAD_PC = 20'h00040;
    localparam logic [19:0] RST_PC  = 20'h00020;
    localparam logic [19:0] ADDRSEL = 20'h00010;
    localparam logic [19:0] LDADDR  = 20'h00008;
    localparam logic [19:0] M_RD    = 20'h00002;
    localparam logic [19:0] M_WR    = 20'h00004;
    localparam logic [19:0] HALTED  = 20'h00001;

    localparam logic [19:0] W_RST = RST_PC | LOAD_PC;
    localparam logic [19:0] W_IF1 = ADDRSEL | M_RD;

    logic [19:0] exp_q[$];

    task automatic chk(input string tag, input logic [19:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Micro-step sequence of one instruction, IF1 up to (not including)
    // the next IF1, built from what each instruction needs to do.
    task automatic build(input logic [2:0] opc, input logic [1:0] o);
        logic [19:0] get_a, get_b, wr_rd;
        get_a = N_RN | LOADA;
        get_b = N_RM | LOADB;
        wr_rd = N_RD | WRITE;
        exp_q.delete();
        exp_q.push_back(W_IF1);
        exp_q.push_back(ADDRSEL | M_RD | LOAD_IR);
        exp_q.push_back(LOAD_PC);
        exp_q.push_back(20'h0);
        if (opc == 3'b111) begin
            for (int i = 0; i < 30; i++) exp_q.push_back(HALTED);
        end else if (opc == 3'b110 && o == 2'b10) begin
            exp_q.push_back(N_RN | V_IMM8 | WRITE);
        end else if (opc == 3'b110 && o == 2'b00) begin
            exp_q.push_back(get_b);
            exp_q.push_back(ASEL | LOADC);
            exp_q.push_back(wr_rd);
        end else if (opc == 3'b101) begin
            if (o != 2'b11) exp_q.push_back(get_a);
            exp_q.push_back(get_b);
            if (o == 2'b01) exp_q.push_back(LOADS);
            else begin
                exp_q.push_back(LOADC);
                exp_q.push_back(wr_rd);
            end
        end else if ((opc == 3'b011 || opc == 3'b100) && o == 2'b00) begin
            exp_q.push_back(get_a);
            exp_q.push_back(BSEL | LOADC);
            exp_q.push_back(LDADDR);
            if (opc == 3'b011) begin
                exp_q.push_back(M_RD);
                exp_q.push_back(M_RD | N_RD | V_MDATA | WRITE);
            end else begin
                exp_q.push_back(N_RD | LOADB);
                exp_q.push_back(ASEL | LOADC);
                exp_q.push_back(M_WR);
            end
        end
    endtask

    // Runs one full instruction starting in IF1; finishes sampled in the next IF1.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input string tag);
        build(opc, o);
        opcode = opc;
        op     = o;
        foreach (exp_q[i]) begin
            chk(tag, exp_q[i]);
            @(posedge clk); #1;
        end
        chk({tag, "_next_if1"}, W_IF1);
    endtask

    initial begin
        int n;
        logic [2:0] ropc;
        logic [1:0] rop;

        #2;
        chk("reset_state", W_RST);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("first_if1", W_IF1);

        run_instr(3'b110, 2'b10, "mov_imm");
        run_instr(3'b101, 2'b00, "add");
        run_instr(3'b101, 2'b01, "cmp");
        run_instr(3'b100, 2'b00, "str");
        run_instr(3'b011, 2'b00, "ldr");
        run_instr(3'b110, 2'b00, "mov_reg");
        run_instr(3'b101, 2'b10, "and");
        run_instr(3'b101, 2'b11, "mvn");
        run_instr(3'b000, 2'b00, "nop");

        for (int k = 0; k < 40; k++) begin
            do begin
                n    = int'($urandom_range(0, 31));
                ropc = n[4:2];
                rop  = n[1:0];
            end while (ropc == 3'b111);
            run_instr(ropc, rop, "random");
        end

        // Reset pulse in MEM_READ of an LDR.
        build(3'b011, 2'b00);
        opcode = 3'b011;
        op     = 2'b00;
        for (int i = 0; i < 7; i++) begin
            chk("ldr_pre_reset", exp_q[i]);
            @(posedge clk); #1;
        end
        chk("ldr_mem_read", M_RD);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_mid_ldr", W_RST);
        @(posedge clk); #1;
        chk("held_in_reset", W_RST);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("if1_after_reset", W_IF1);

        // HALT: fetch, then stay halted whatever the inputs do.
        build(3'b111, 2'b00);
        opcode = 3'b111;
        op     = 2'b00;
        foreach (exp_q[i]) begin
            chk("halt", exp_q[i]);
            @(posedge clk); #1;
            if (i >= 4) begin
                n      = int'($urandom_range(0, 31));
                opcode = n[4:2];
                op     = n[1:0];
            end
        end
        chk("halt_hold", HALTED);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_from_halt", W_RST);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("if1_after_halt_reset", W_IF1);
        run_instr(3'b110, 2'b10, "mov_imm_after_halt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // write and a memory write never coincide
    always @(negedge clk) begin
        if (reset_n) begin
            total++;
            assert (!(write && mem_cmd == 2'b10)) else begin
                bad++;
                $error("FAIL write_vs_memwrite observed=%b%b expected=not_both", write, mem_cmd);
            end
        end
    end

endmodule
